// File: rtl/sdm_sw_alloc_if.sv
// ----------------------------------------------------------------------------
// sdm_sw_alloc_if
//  Request/grant bundle between the input-buffer route decoders (master) and
//  the SDM switch allocator (slave). Also carries the crossbar configuration
//  that the allocator drives.
//
//  Signals (N = PN*VCN sub-channels)
//   req      N        header request of input sub-channel i
//   req_dir  N*DIRW   requested output port of input i (slice i)
//   tail     N        tail-flit transfer pulse of input i
//   gnt      N        input i is bound to an output sub-channel
//   gnt_sc   N*SCW    output sub-channel index bound to input i
//   err      N        request of input i rejected (pulse)
//   cfg_v    N        output sub-channel j is busy
//   cfg_src  N*IW     input index driving output sub-channel j
// ----------------------------------------------------------------------------
interface sdm_sw_alloc_if #(
    parameter int PN   = 5,
    parameter int VCN  = 2,
    parameter int DIRW = (PN > 1) ? $clog2(PN) : 1,
    parameter int SCW  = (VCN > 1) ? $clog2(VCN) : 1,
    parameter int IW   = (PN * VCN > 1) ? $clog2(PN * VCN) : 1
);
    localparam int N = PN * VCN;

    logic [N-1:0]      req;
    logic [N*DIRW-1:0] req_dir;
    logic [N-1:0]      tail;
    logic [N-1:0]      gnt;
    logic [N*SCW-1:0]  gnt_sc;
    logic [N-1:0]      err;
    logic [N-1:0]      cfg_v;
    logic [N*IW-1:0]   cfg_src;

    modport master (
        output req, req_dir, tail,
        input  gnt, gnt_sc, err, cfg_v, cfg_src
    );

    modport slave (
        input  req, req_dir, tail,
        output gnt, gnt_sc, err, cfg_v, cfg_src
    );
endinterface

// File: rtl/sdm_sw_alloc.sv
// ----------------------------------------------------------------------------
// sdm_sw_alloc
//  Switch allocator for the SDM wormhole router. Each input sub-channel that
//  presents a valid header request is bound to one free sub-channel of the
//  requested output port; every output port runs its own round-robin pointer
//  over all N inputs. A binding lives until the packet's tail handshake.
//
//  Parameters
//   PN     number of router ports (0=S,1=W,2=N,3=E,4=L when PN==5)
//   VCN    sub-channels per port, N = PN*VCN
//   XYCHK  1: reject W/E inputs that target S/N (XY dimension order)
//   DIRW / SCW / IW  widths of direction, sub-channel and input indices
//
//  Ports
//   clk  rising-edge clock
//   rst  asynchronous reset, active high
//   bus  sdm_sw_alloc_if.slave : req/req_dir/tail in,
//        gnt/gnt_sc/err/cfg_v/cfg_src out (all registered)
// ----------------------------------------------------------------------------
module sdm_sw_alloc #(
    parameter int PN    = 5,
    parameter int VCN   = 2,
    parameter int XYCHK = 1,
    parameter int DIRW  = (PN > 1) ? $clog2(PN) : 1,
    parameter int SCW   = (VCN > 1) ? $clog2(VCN) : 1,
    parameter int IW    = (PN * VCN > 1) ? $clog2(PN * VCN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    sdm_sw_alloc_if.slave bus
);
    localparam int N = PN * VCN;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BOUND = 1'b1
    } in_st_t;

    // Per-input state
    in_st_t          st      [N];
    logic [IW-1:0]   bj      [N];   // output sub-channel held by input i
    logic [1:0]      err_cnt [N];   // cycles an invalid request has been held, mod 4

    // Per-output-port round-robin pointer
    logic [IW-1:0]   rr      [PN];

    // Registered outputs
    logic [N*SCW-1:0] gnt_sc_q;
    logic [N-1:0]     err_q;
    logic [N-1:0]     cfg_v_q;
    logic [N*IW-1:0]  cfg_src_q;
    logic [N-1:0]     gnt_w;

    // Request decode
    logic [DIRW-1:0]  dir_of  [N];
    logic [N-1:0]     ok_req;
    logic [N-1:0]     idle;

    // Arbitration result per output port
    logic [PN-1:0]    win_v;
    logic [IW-1:0]    win_i   [PN];
    logic [SCW-1:0]   win_k   [PN];

    // Arbitration result folded back onto inputs
    logic [N-1:0]     hit;
    logic [IW-1:0]    hit_j   [N];
    logic [SCW-1:0]   hit_k   [N];

    // A request is legal if the direction exists, is not a U-turn and, with
    // the XY check enabled, does not turn from the X dimension back into Y.
    function automatic logic req_ok(input int i, input logic [DIRW-1:0] d);
        int dv;
        int own;
        dv  = int'(d);
        own = i / VCN;
        if (dv >= PN)
            return 1'b0;
        if (dv == own)
            return 1'b0;
        if ((XYCHK != 0) && (PN == 5) && ((own == 1) || (own == 3)) &&
            ((dv == 0) || (dv == 2)))
            return 1'b0;
        return 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dir_of[i] = bus.req_dir[i*DIRW +: DIRW];
            ok_req[i] = req_ok(i, dir_of[i]);
            idle[i]   = (st[i] == S_IDLE);
        end
    end

    // Per-port arbitration. Free sub-channels come from the registered
    // cfg_v, so a sub-channel released at this edge is only offered again
    // from the following cycle.
    always_comb begin
        int   c;
        logic has_free;
        c        = 0;
        has_free = 1'b0;
        for (int o = 0; o < PN; o++) begin
            win_v[o] = 1'b0;
            win_i[o] = '0;
            win_k[o] = '0;
            has_free = 1'b0;
            // Scan downwards so the lowest free index is the one kept.
            for (int k = VCN - 1; k >= 0; k--) begin
                if (!cfg_v_q[o*VCN + k]) begin
                    has_free = 1'b1;
                    win_k[o] = SCW'(k);
                end
            end
            if (has_free) begin
                for (int s = 0; s < N; s++) begin
                    c = (int'(rr[o]) + s) % N;
                    if (!win_v[o] && idle[c] && bus.req[c] && ok_req[c] &&
                        (int'(dir_of[c]) == o)) begin
                        win_v[o] = 1'b1;
                        win_i[o] = IW'(c);
                    end
                end
            end
        end
    end

    // An input requests exactly one port, so at most one port can pick it.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit_j[i] = '0;
            hit_k[i] = '0;
        end
        for (int o = 0; o < PN; o++) begin
            if (win_v[o]) begin
                hit[win_i[o]]   = 1'b1;
                hit_j[win_i[o]] = IW'(o * VCN + int'(win_k[o]));
                hit_k[win_i[o]] = win_k[o];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                st[i]      <= S_IDLE;
                bj[i]      <= '0;
                err_cnt[i] <= '0;
            end
            for (int o = 0; o < PN; o++) begin
                rr[o] <= '0;
            end
            gnt_sc_q  <= '0;
            err_q     <= '0;
            cfg_v_q   <= '0;
            cfg_src_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                // err fires on the first sampled cycle of an invalid request
                // and then on every 4th cycle while it is held.
                if (idle[i] && bus.req[i] && !ok_req[i]) begin
                    err_q[i]   <= (err_cnt[i] == 2'd0);
                    err_cnt[i] <= err_cnt[i] + 2'd1;
                end else begin
                    err_q[i]   <= 1'b0;
                    err_cnt[i] <= '0;
                end

                case (st[i])
                    S_IDLE: begin
                        if (hit[i]) begin
                            st[i]                       <= S_BOUND;
                            bj[i]                       <= hit_j[i];
                            gnt_sc_q[i*SCW +: SCW]      <= hit_k[i];
                            cfg_v_q[hit_j[i]]           <= 1'b1;
                            cfg_src_q[hit_j[i]*IW +: IW] <= IW'(i);
                        end
                    end
                    S_BOUND: begin
                        // A request arriving together with tail is not
                        // considered here; it competes from the next cycle.
                        if (bus.tail[i]) begin
                            st[i]                     <= S_IDLE;
                            gnt_sc_q[i*SCW +: SCW]    <= '0;
                            cfg_v_q[bj[i]]            <= 1'b0;
                            cfg_src_q[bj[i]*IW +: IW] <= '0;
                        end
                    end
                    default: st[i] <= S_IDLE;
                endcase
            end

            for (int o = 0; o < PN; o++) begin
                if (win_v[o]) begin
                    rr[o] <= (int'(win_i[o]) == N - 1) ? '0 : win_i[o] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_w = '0;
        for (int i = 0; i < N; i++) begin
            gnt_w[i] = (st[i] == S_BOUND);
        end
    end

    assign bus.gnt     = gnt_w;
    assign bus.gnt_sc  = gnt_sc_q;
    assign bus.err     = err_q;
    assign bus.cfg_v   = cfg_v_q;
    assign bus.cfg_src = cfg_src_q;

endmodule

// File: tb/tb_sdm_sw_alloc.sv
// ----------------------------------------------------------------------------
// tb_sdm_sw_alloc
//  Bench for sdm_sw_alloc: a 5-port/2-sub-channel instance driven by a vector
//  table, hand sequences and random traffic checked against an array-based
//  model, plus a 5-port/1-sub-channel instance for round-robin fairness.
// ----------------------------------------------------------------------------
module tb_sdm_sw_alloc;
    localparam int PN   = 5;
    localparam int VCN  = 2;
    localparam int N    = PN * VCN;
    localparam int DIRW = 3;
    localparam int SCW  = 1;
    localparam int IW   = 4;
    localparam int N1   = 5;
    localparam int IW1  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdm_sw_alloc_if #(.PN(PN), .VCN(VCN), .DIRW(DIRW), .SCW(SCW), .IW(IW)) bus ();
    sdm_sw_alloc_if #(.PN(5), .VCN(1), .DIRW(3), .SCW(1), .IW(IW1)) bus1 ();

    sdm_sw_alloc #(.PN(PN), .VCN(VCN), .XYCHK(1), .DIRW(DIRW), .SCW(SCW), .IW(IW))
        u_dut (.clk(clk), .rst(rst), .bus(bus));
    sdm_sw_alloc #(.PN(5), .VCN(1), .XYCHK(1), .DIRW(3), .SCW(1), .IW(IW1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step_clk;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [N-1:0] bs(input int a = -1, input int b = -1,
                                        input int c = -1, input int d = -1);
        logic [N-1:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        if (d >= 0) r[d] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*IW-1:0] sr(input int j0 = -1, input int v0 = 0,
                                           input int j1 = -1, input int v1 = 0);
        logic [N*IW-1:0] r;
        r = '0;
        if (j0 >= 0) r[j0*IW +: IW] = IW'(v0);
        if (j1 >= 0) r[j1*IW +: IW] = IW'(v1);
        return r;
    endfunction

    task automatic drive_main(input logic [N-1:0] rq, input int d, input logic [N-1:0] tl);
        bus.req  = rq;
        bus.tail = tl;
        for (int i = 0; i < N; i++) bus.req_dir[i*DIRW +: DIRW] = DIRW'(d);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0]    req;
        int              dir;
        logic [N-1:0]    tail;
        logic [N-1:0]    gnt;
        logic [N-1:0]    sc;
        logic [N-1:0]    err;
        logic [N-1:0]    cfgv;
        logic [N*IW-1:0] src;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] rq, input int d, input logic [N-1:0] tl,
                                input logic [N-1:0] g, input logic [N-1:0] s,
                                input logic [N-1:0] e, input logic [N-1:0] cv,
                                input logic [N*IW-1:0] src);
        vec_t v;
        v.req = rq; v.dir = d; v.tail = tl;
        v.gnt = g; v.sc = s; v.err = e; v.cfgv = cv; v.src = src;
        return v;
    endfunction

    vec_t tbl[$];

    // ---------------- reference model ----------------
    int m_sc  [N];   // global output sub-channel held by input, -1 if idle
    int m_own [N];   // input owning output sub-channel, -1 if free
    int m_rr  [PN];
    int m_run [N];   // consecutive cycles of an invalid request
    bit m_err [N];
    bit r_rq  [N];
    int r_dr  [N];
    bit r_tl  [N];

    function automatic bit m_ok(input int i, input int d);
        int p;
        p = i / VCN;
        if (d >= PN) return 1'b0;
        if (d == p) return 1'b0;
        if ((p == 1 || p == 3) && (d == 0 || d == 2)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset;
        for (int i = 0; i < N; i++) begin
            m_sc[i] = -1; m_own[i] = -1; m_run[i] = 0; m_err[i] = 1'b0;
            r_rq[i] = 1'b0; r_dr[i] = 0; r_tl[i] = 1'b0;
        end
        for (int o = 0; o < PN; o++) m_rr[o] = 0;
    endtask

    task automatic m_step;
        int win [PN];
        int wsc [PN];
        for (int i = 0; i < N; i++) begin
            if (m_sc[i] < 0 && r_rq[i] && !m_ok(i, r_dr[i])) begin
                m_run[i]++;
                m_err[i] = ((m_run[i] % 4) == 1);
            end else begin
                m_run[i] = 0;
                m_err[i] = 1'b0;
            end
        end
        for (int o = 0; o < PN; o++) begin
            win[o] = -1;
            wsc[o] = -1;
            for (int k = 0; k < VCN; k++)
                if (wsc[o] < 0 && m_own[o*VCN + k] < 0) wsc[o] = o*VCN + k;
            if (wsc[o] >= 0) begin
                for (int s = 0; s < N; s++) begin
                    int c;
                    c = (m_rr[o] + s) % N;
                    if (win[o] < 0 && m_sc[c] < 0 && r_rq[c] && m_ok(c, r_dr[c]) && r_dr[c] == o)
                        win[o] = c;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_sc[i] >= 0 && r_tl[i]) begin
                m_own[m_sc[i]] = -1;
                m_sc[i] = -1;
            end
        end
        for (int o = 0; o < PN; o++) begin
            if (win[o] >= 0) begin
                m_sc[win[o]] = wsc[o];
                m_own[wsc[o]] = win[o];
                m_rr[o] = (win[o] + 1) % N;
            end
        end
    endtask

    task automatic m_check;
        logic [N-1:0]    eg, es, ee, ev;
        logic [N*IW-1:0] esrc;
        eg = '0; es = '0; ee = '0; ev = '0; esrc = '0;
        for (int i = 0; i < N; i++) begin
            eg[i] = (m_sc[i] >= 0);
            if (m_sc[i] >= 0) es[i] = ((m_sc[i] % VCN) != 0);
            ee[i] = m_err[i];
            ev[i] = (m_own[i] >= 0);
            if (m_own[i] >= 0) esrc[i*IW +: IW] = IW'(m_own[i]);
        end
        chk("rnd.gnt", 64'(bus.gnt), 64'(eg));
        chk("rnd.gnt_sc", 64'(bus.gnt_sc), 64'(es));
        chk("rnd.err", 64'(bus.err), 64'(ee));
        chk("rnd.cfg_v", 64'(bus.cfg_v), 64'(ev));
        chk("rnd.cfg_src", 64'(bus.cfg_src), 64'(esrc));
    endtask

    task automatic r_gen;
        for (int i = 0; i < N; i++) begin
            if (m_sc[i] >= 0) begin
                r_tl[i] = ($urandom % 4) == 0;
                r_rq[i] = r_tl[i] && (($urandom % 2) == 0);
                if (r_rq[i]) r_dr[i] = int'($urandom % 5);
            end else begin
                r_tl[i] = ($urandom % 8) == 0;
                if (r_rq[i]) begin
                    if (($urandom % 8) == 0) r_rq[i] = 1'b0;
                end else if (($urandom % 3) == 0) begin
                    r_rq[i] = 1'b1;
                    r_dr[i] = (($urandom % 4) == 0) ? int'($urandom % 8) : int'($urandom % 5);
                end
            end
            bus.req[i]  = r_rq[i];
            bus.tail[i] = r_tl[i];
            bus.req_dir[i*DIRW +: DIRW] = DIRW'(r_dr[i]);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N1-1:0] exp1;
        int ord [4];
        int holder;

        rst = 1'b1;
        drive_main('0, 0, '0);
        bus1.req = '0; bus1.tail = '0; bus1.req_dir = '0;
        step_clk();
        step_clk();

        // Reset state
        chk("rst.gnt", 64'(bus.gnt), 64'(0));
        chk("rst.gnt_sc", 64'(bus.gnt_sc), 64'(0));
        chk("rst.err", 64'(bus.err), 64'(0));
        chk("rst.cfg_v", 64'(bus.cfg_v), 64'(0));
        chk("rst.cfg_src", 64'(bus.cfg_src), 64'(0));
        chk("rst.gnt1", 64'(bus1.gnt), 64'(0));
        rst = 1'b0;

        //            req             dir tail     gnt            sc       err      cfg_v        cfg_src
        tbl.push_back(mk(bs(8),        0, '0,      bs(8),         '0,      '0,      bs(0),       sr(0,8)));
        tbl.push_back(mk('0,           0, bs(8),   '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(0,2,4,6),  4, '0,      bs(0),         '0,      '0,      bs(8),       sr(8,0)));
        tbl.push_back(mk(bs(2,4,6),    4, '0,      bs(0,2),       bs(2),   '0,      bs(8,9),     sr(8,0,9,2)));
        tbl.push_back(mk(bs(4,6),      4, '0,      bs(0,2),       bs(2),   '0,      bs(8,9),     sr(8,0,9,2)));
        tbl.push_back(mk(bs(4,6),      4, bs(0),   bs(2),         bs(2),   '0,      bs(9),       sr(9,2)));
        tbl.push_back(mk(bs(4,6),      4, '0,      bs(2,4),       bs(2),   '0,      bs(8,9),     sr(8,4,9,2)));
        tbl.push_back(mk(bs(0,6),      4, bs(2),   bs(4),         '0,      '0,      bs(8),       sr(8,4)));
        tbl.push_back(mk(bs(0,6),      4, '0,      bs(4,6),       bs(6),   '0,      bs(8,9),     sr(8,4,9,6)));
        tbl.push_back(mk(bs(0),        4, bs(4,6), '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(0),        4, '0,      bs(0),         '0,      '0,      bs(8),       sr(8,0)));
        tbl.push_back(mk('0,           0, bs(0),   '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(2),        0, '0,      '0,            '0,      bs(2),   '0,          '0));
        tbl.push_back(mk(bs(2),        0, '0,      '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(2),        0, '0,      '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(2),        0, '0,      '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(2),        0, '0,      '0,            '0,      bs(2),   '0,          '0));
        tbl.push_back(mk(bs(0),        0, '0,      '0,            '0,      bs(0),   '0,          '0));
        tbl.push_back(mk('0,           0, bs(3),   '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(8),        0, '0,      bs(8),         '0,      '0,      bs(0),       sr(0,8)));
        tbl.push_back(mk(bs(8),        0, bs(8),   '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(8),        0, '0,      bs(8),         '0,      '0,      bs(0),       sr(0,8)));
        tbl.push_back(mk('0,           0, bs(8),   '0,            '0,      '0,      '0,          '0));
        tbl.push_back(mk(bs(4),        6, '0,      '0,            '0,      bs(4),   '0,          '0));
        tbl.push_back(mk('0,           0, '0,      '0,            '0,      '0,      '0,          '0));

        for (int v = 0; v < tbl.size(); v++) begin
            drive_main(tbl[v].req, tbl[v].dir, tbl[v].tail);
            step_clk();
            chk($sformatf("tbl[%0d].gnt", v), 64'(bus.gnt), 64'(tbl[v].gnt));
            chk($sformatf("tbl[%0d].gnt_sc", v), 64'(bus.gnt_sc), 64'(tbl[v].sc));
            chk($sformatf("tbl[%0d].err", v), 64'(bus.err), 64'(tbl[v].err));
            chk($sformatf("tbl[%0d].cfg_v", v), 64'(bus.cfg_v), 64'(tbl[v].cfgv));
            chk($sformatf("tbl[%0d].cfg_src", v), 64'(bus.cfg_src), 64'(tbl[v].src));
        end

        // Mid-cycle reset with three bindings held, then rr restarts at 0.
        drive_main(bs(2,4,8), 4, '0);
        bus.req_dir[8*DIRW +: DIRW] = 3'd0;
        bus.req_dir[4*DIRW +: DIRW] = 3'd3;
        step_clk();
        chk("rstmid.pre_gnt", 64'(bus.gnt), 64'(bs(2,4,8)));
        chk("rstmid.pre_cfg_v", 64'(bus.cfg_v), 64'(bs(0,6,8)));
        drive_main('0, 0, '0);
        rst = 1'b1;
        #1;
        chk("rstmid.gnt", 64'(bus.gnt), 64'(0));
        chk("rstmid.cfg_v", 64'(bus.cfg_v), 64'(0));
        step_clk();
        rst = 1'b0;
        drive_main(bs(0,6), 4, '0);
        step_clk();
        chk("rstmid.tie_gnt", 64'(bus.gnt), 64'(bs(0)));
        chk("rstmid.tie_src", 64'(bus.cfg_src), 64'(sr(8,0)));
        drive_main('0, 0, bs(0));
        step_clk();
        chk("rstmid.clear", 64'(bus.gnt), 64'(0));

        // Fairness on a single-sub-channel router: S,W,N,L all hammer E.
        bus1.req = 5'b10111;
        for (int i = 0; i < N1; i++) bus1.req_dir[i*3 +: 3] = 3'd3;
        step_clk();
        chk("fair.first", 64'(bus1.gnt), 64'(5'b00001));
        ord[0] = 1; ord[1] = 2; ord[2] = 4; ord[3] = 0;
        holder = 0;
        for (int r = 0; r < 4; r++) begin
            exp1 = '0;
            exp1[holder] = 1'b1;
            bus1.tail = exp1;
            step_clk();
            chk($sformatf("fair[%0d].rel", r), 64'(bus1.gnt), 64'(0));
            bus1.tail = '0;
            step_clk();
            exp1 = '0;
            exp1[ord[r]] = 1'b1;
            chk($sformatf("fair[%0d].gnt", r), 64'(bus1.gnt), 64'(exp1));
            chk($sformatf("fair[%0d].src", r), 64'(bus1.cfg_src[3*IW1 +: IW1]), 64'(ord[r]));
            holder = ord[r];
        end
        exp1 = '0;
        exp1[holder] = 1'b1;
        bus1.tail = exp1;
        bus1.req = '0;
        step_clk();
        bus1.tail = '0;
        chk("fair.end", 64'(bus1.gnt), 64'(0));

        // Random traffic against the model.
        rst = 1'b1;
        drive_main('0, 0, '0);
        step_clk();
        rst = 1'b0;
        m_reset();
        m_check();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_gen();
            m_step();
            step_clk();
            m_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
